n_serial_bit_decoder: RTL

//  Receive-side decoder for the Nintendo single-wire serial line (GC/N64 controller port). Sits between
//  n_serial_io_buffer (clean synchronized rx) and the gc_controller state machine. Measures low-pulse

---
 rtl/n_serial_bit_decoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/n_serial_bit_decoder.sv
// Nintendo single-wire serial receive decoder: low-pulse width -> bit, MSB-first bytes, frame pulses.
// Optional glitch rejection of short lows under NSERIAL_RX_GLITCH_FILTER_EN.
module n_serial_bit_decoder #(
    parameter int BIT_THRESHOLD = 50,
    parameter int LOW_TIMEOUT   = 200,
    parameter int IDLE_TIMEOUT  = 125
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
    ,
    parameter int MIN_LOW       = 5
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_start,
    output logic       rx_stop,
    output logic       rx_error,
    output logic [7:0] rx_data,
    output logic       rx_strobe
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOW   = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_STUCK = 2'd3;

    localparam logic [7:0] BIT_TH  = 8'(BIT_THRESHOLD);
    localparam logic [7:0] LOW_TO  = 8'(LOW_TIMEOUT);
    localparam logic [7:0] IDLE_TO = 8'(IDLE_TIMEOUT);

    logic [1:0] state;
    logic [7:0] shreg;
    logic [2:0] bit_count;
    logic [7:0] low_cnt;
    logic [7:0] high_cnt;
    logic       last_bit;

    logic [7:0] low_inc;
    logic [7:0] high_inc;
    logic       bit_val;
    logic [7:0] shift_next;
    logic       glitch;
    logic       late_start;

`ifdef NSERIAL_RX_GLITCH_FILTER_EN
    localparam logic [7:0] MIN_LO = 8'(MIN_LOW);
    // Set while the current low began from idle, so a rejected glitch knows where to return.
    logic from_idle;
`endif

    always_comb begin
        low_inc    = (low_cnt == 8'hFF) ? low_cnt : low_cnt + 8'd1;
        high_inc   = (high_cnt == 8'hFF) ? high_cnt : high_cnt + 8'd1;
        bit_val    = (low_cnt < BIT_TH);
        shift_next = {shreg[6:0], bit_val};
        glitch     = 1'b0;
        late_start = 1'b0;
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
        glitch     = (low_cnt < MIN_LO);
        late_start = from_idle && (low_inc == MIN_LO);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            shreg     <= 8'd0;
            bit_count <= 3'd0;
            low_cnt   <= 8'd0;
            high_cnt  <= 8'd0;
            last_bit  <= 1'b0;
            rx_start  <= 1'b0;
            rx_stop   <= 1'b0;
            rx_error  <= 1'b0;
            rx_data   <= 8'd0;
            rx_strobe <= 1'b0;
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
            from_idle <= 1'b0;
`endif
        end else begin
            rx_start  <= 1'b0;
            rx_stop   <= 1'b0;
            rx_error  <= 1'b0;
            rx_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx) begin
                        // New frame: drop any leftover bit alignment from the previous one.
                        low_cnt   <= 8'd1;
                        bit_count <= 3'd0;
                        shreg     <= 8'd0;
                        state     <= S_LOW;
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
                        from_idle <= 1'b1;
`else
                        rx_start  <= 1'b1;
`endif
                    end
                end
                S_LOW: begin
                    if (!rx) begin
                        low_cnt <= low_inc;
                        if (late_start) begin
                            rx_start <= 1'b1;
                        end
                        if (low_inc == LOW_TO) begin
                            rx_error <= 1'b1;
                            state    <= S_STUCK;
                        end
                    end else if (glitch) begin
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
                        state <= from_idle ? S_IDLE : S_HIGH;
`endif
                    end else begin
                        shreg     <= shift_next;
                        bit_count <= bit_count + 3'd1;
                        last_bit  <= bit_val;
                        high_cnt  <= 8'd1;
                        state     <= S_HIGH;
                        if (bit_count == 3'd7) begin
                            rx_data   <= shift_next;
                            rx_strobe <= 1'b1;
                        end
                    end
                end
                S_HIGH: begin
                    if (!rx) begin
                        low_cnt <= 8'd1;
                        state   <= S_LOW;
`ifdef NSERIAL_RX_GLITCH_FILTER_EN
                        from_idle <= 1'b0;
`endif
                    end else begin
                        high_cnt <= high_inc;
                        if (high_inc == IDLE_TO) begin
                            // Clean end only if exactly one '1' follows whole bytes.
                            if (bit_count == 3'd1 && last_bit) begin
                                rx_stop <= 1'b1;
                            end else begin
                                rx_error <= 1'b1;
                            end
                            state <= S_IDLE;
                        end
                    end
                end
                S_STUCK: begin
                    if (rx) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
